// File: rtl/nios_ii_ocm_pkg.sv
// Shared types and helpers for the pipelined Nios II on-chip memory slave.
// Holds the controller state encoding, the latency ceiling and a clog2 helper.
package nios_ii_ocm_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } ocm_state_e;

  localparam int MAX_READ_LATENCY = 2;

  // Returns at least 1 so that a one-word memory still has an address bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/nios_ii_ocm_bytemem.sv
// Single-port byte-enabled RAM with synchronous read and a shared clock enable.
// The read register only updates on a read strobe, so it holds the last word read.
module nios_ii_ocm_bytemem
  import nios_ii_ocm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/nios_ii_onchip_memory_pipelined.sv
// Avalon-MM pipelined on-chip RAM slave with post-reset scrub, waitrequest
// back-pressure and a 1- or 2-cycle readdatavalid pipeline.
module nios_ii_onchip_memory_pipelined
  import nios_ii_ocm_pkg::*;
#(
  parameter int              DATA_W         = 32,
  parameter int              DEPTH          = 1024,
  parameter int              ADDR_W         = clog2(DEPTH),
  parameter int              READ_LATENCY   = 2,
  parameter bit              CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                reset_req,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = DEPTH[ADDR_W:0];

  ocm_state_e        state;
  logic [ADDR_W-1:0] cnt;
  logic              en;
  logic              scrubbing;
  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W/8-1:0] ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic              v1;
  logic              ok1;
  logic              v_last;
  logic [DATA_W-1:0] s1_data;

  assign en          = clken & ~reset_req;
  assign waitrequest = (state != RUN) | ~en;
  assign in_range    = ({1'b0, address} < DEPTH_V);
  assign wr_acc      = chipselect & write & ~waitrequest;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;
  assign scrubbing   = (state == SCRUB) && CLEAR_ON_RESET;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ram_we    = wr_acc & in_range;
    ram_re    = rd_acc & in_range;
    ram_addr  = address;
    ram_be    = byteenable;
    ram_wdata = writedata;
    if (scrubbing) begin
      ram_we    = 1'b1;
      ram_re    = 1'b0;
      ram_addr  = cnt;
      ram_be    = '1;
      ram_wdata = INIT_VALUE;
    end
  end

  nios_ii_ocm_bytemem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .en    (en),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCRUB;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (en) begin
      case (state)
        SCRUB: begin
          if (!CLEAR_ON_RESET || cnt == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ok1 only moves on an accepted read, so readdata stays 0 until the first response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1  <= 1'b0;
      ok1 <= 1'b0;
    end else if (en) begin
      v1 <= rd_acc;
      if (rd_acc) ok1 <= in_range;
    end
  end

  assign s1_data = ok1 ? ram_q : '0;

  if (READ_LATENCY >= MAX_READ_LATENCY) begin : g_lat2
    logic              v2;
    logic [DATA_W-1:0] data2;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2    <= 1'b0;
        data2 <= '0;
      end else if (en) begin
        v2 <= v1;
        if (v1) data2 <= s1_data;
      end
    end

    assign v_last   = v2;
    assign readdata = data2;
  end else begin : g_lat1
    assign v_last   = v1;
    assign readdata = s1_data;
  end

  // A response held through a stall is presented on the first enabled cycle.
  assign readdatavalid = v_last & en;

endmodule

// File: tb/tb_nios_ii_onchip_memory_pipelined.sv
// Scoreboard bench: two instances (1024 words / latency 2, 1000 words / latency 1)
// share one bus; each has its own expected-response queue and monitor.
module tb_nios_ii_onchip_memory_pipelined;

  typedef struct {
    logic [31:0] data;
    int          issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic        reset_req;

  logic        waitrequest_a, readdatavalid_a, init_done_a;
  logic [31:0] readdata_a;
  logic        waitrequest_b, readdatavalid_b, init_done_b;
  logic [31:0] readdata_b;

  int   vectors     = 0;
  int   miscompares = 0;
  int   en_cyc      = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  localparam logic [31:0] INIT_B = 32'h5A5A_5A5A;
  localparam logic [31:0] BURST [8] = '{
    32'h0000_0011, 32'h0000_2200, 32'h0033_0000, 32'h4400_0000,
    32'h1234_5678, 32'h8765_4321, 32'hFFFF_0000, 32'h0F0F_F0F0
  };

  always #5 clk = ~clk;

  nios_ii_onchip_memory_pipelined u_dut_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .clken         (clken),
    .reset_req     (reset_req),
    .waitrequest   (waitrequest_a),
    .readdata      (readdata_a),
    .readdatavalid (readdatavalid_a),
    .init_done     (init_done_a)
  );

  nios_ii_onchip_memory_pipelined #(
    .DEPTH        (1000),
    .READ_LATENCY (1),
    .INIT_VALUE   (INIT_B)
  ) u_dut_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .byteenable    (byteenable),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .clken         (clken),
    .reset_req     (reset_req),
    .waitrequest   (waitrequest_b),
    .readdata      (readdata_b),
    .readdatavalid (readdatavalid_b),
    .init_done     (init_done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (clken && !reset_req) en_cyc <= en_cyc + 1;

  // Monitors: pop one expectation per presented response; check data and latency.
  always @(negedge clk) begin
    exp_t e;
    if (readdatavalid_a) begin
      if (q_a.size() == 0) check("unexpected_valid_a", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("rdata_a", readdata_a, e.data);
        check("latency_a", 32'(en_cyc - e.issue), 32'd2);
      end
    end
    if (readdatavalid_b) begin
      if (q_b.size() == 0) check("unexpected_valid_b", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("rdata_b", readdata_b, e.data);
        check("latency_b", 32'(en_cyc - e.issue), 32'd1);
      end
    end
  end

  // Drives one command for one cycle; call at posedge+1, returns at the next posedge+1.
  task automatic op(input logic rd, input logic wr, input logic [9:0] addr,
                    input logic [3:0] be, input logic [31:0] wd,
                    input logic [31:0] exp_a, input logic [31:0] exp_b);
    chipselect = 1'b1;
    read       = rd;
    write      = wr;
    address    = addr;
    byteenable = be;
    writedata  = wd;
    if (rd && !wr) begin
      q_a.push_back('{data: exp_a, issue: en_cyc});
      q_b.push_back('{data: exp_b, issue: en_cyc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int done_a;
    int done_b;
    reset_n    = 1'b0;
    clken      = 1'b1;
    reset_req  = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest_a", 32'(waitrequest_a), 32'd1);
    check("rst_waitrequest_b", 32'(waitrequest_b), 32'd1);
    check("rst_rdv_a", 32'(readdatavalid_a), 32'd0);
    check("rst_rdv_b", 32'(readdatavalid_b), 32'd0);
    check("rst_readdata_a", readdata_a, 32'd0);
    check("rst_readdata_b", readdata_b, 32'd0);
    check("rst_init_done_a", 32'(init_done_a), 32'd0);
    check("rst_init_done_b", 32'(init_done_b), 32'd0);

    // Start a scrub, then interrupt it with reset_n so it restarts from 0.
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midscrub_init_done_a", 32'(init_done_a), 32'd0);
    check("midscrub_waitrequest_a", 32'(waitrequest_a), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full scrub with a 10-cycle reset_req freeze after 100 enabled cycles.
    done_a = 0;
    done_b = 0;
    for (int n = 1; n <= 1200; n++) begin
      @(posedge clk);
      #1;
      if (n == 100) reset_req = 1'b1;
      if (n == 110) reset_req = 1'b0;
      if (done_a == 0 && init_done_a) done_a = n;
      if (done_b == 0 && init_done_b) done_b = n;
      if (done_a != 0 && done_b != 0) break;
    end
    check("scrub_cycles_a", 32'(done_a), 32'd1034);
    check("scrub_cycles_b", 32'(done_b), 32'd1010);
    check("live_waitrequest_a", 32'(waitrequest_a), 32'd0);
    check("live_waitrequest_b", 32'(waitrequest_b), 32'd0);
    check("pre_read_readdata_a", readdata_a, 32'd0);
    check("pre_read_readdata_b", readdata_b, 32'd0);

    // Scrubbed contents, including the out-of-range 1023 on the 1000-word instance.
    op(1'b1, 1'b0, 10'd0,    4'hF, '0, 32'd0, INIT_B);
    op(1'b1, 1'b0, 10'd511,  4'hF, '0, 32'd0, INIT_B);
    op(1'b1, 1'b0, 10'd999,  4'hF, '0, 32'd0, INIT_B);
    op(1'b1, 1'b0, 10'd1023, 4'hF, '0, 32'd0, 32'd0);

    // Byte-lane merge, then read-after-write on the very next cycle.
    op(1'b0, 1'b1, 10'd5, 4'b1111, 32'hDEAD_BEEF, '0, '0);
    op(1'b0, 1'b1, 10'd5, 4'b0101, 32'h1122_3344, '0, '0);
    op(1'b1, 1'b0, 10'd5, 4'hF, '0, 32'hDE22_BE44, 32'hDE22_BE44);

    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 10'(16 + i), 4'hF, BURST[i], '0, '0);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 10'(16 + i), 4'hF, '0, BURST[i], BURST[i]);
    idle(4);

    // Read, then freeze with clken=0 for 3 cycles while the response is due.
    op(1'b1, 1'b0, 10'd16, 4'hF, '0, BURST[0], BURST[0]);
    chipselect = 1'b0;
    read       = 1'b0;
    clken      = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_rdv_a", 32'(readdatavalid_a), 32'd0);
      check("stall_rdv_b", 32'(readdatavalid_b), 32'd0);
      check("stall_hold_a", readdata_a, BURST[7]);
      @(posedge clk);
      #1;
    end
    clken = 1'b1;
    idle(4);

    // Address 1010 is live on 1024 words but beyond the 1000-word array.
    op(1'b0, 1'b1, 10'd1010, 4'hF, 32'hA5A5_A5A5, '0, '0);
    op(1'b1, 1'b0, 10'd1010, 4'hF, '0, 32'hA5A5_A5A5, 32'd0);
    op(1'b1, 1'b0, 10'd999,  4'hF, '0, 32'd0, INIT_B);

    // read and write together: the write lands, no response is produced.
    op(1'b1, 1'b1, 10'd40, 4'hF, 32'hCAFE_F00D, '0, '0);
    op(1'b1, 1'b0, 10'd40, 4'hF, '0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    idle(1);

    for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    idle(5);
    check("drain_q_a", 32'(q_a.size()), 32'd0);
    check("drain_q_b", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_ii_onchip_memory_pipelined.md
Name: nios_ii_onchip_memory_pipelined

Overview:
Parametrised Avalon-MM on-chip RAM slave for the Nios II system, succeeding the fixed 32x1024 single-port memory. Adds configurable width, depth and read latency, an explicit read strobe with readdatavalid pipelining, and waitrequest back-pressure. Also adds an optional post-reset scrub engine that fills the array with a known value before accepting traffic. Sits on the CPU data master or DMA interconnect as a plain pipelined slave.

Parameters:
DATA_W, 32, data width in bits; multiple of 8.
DEPTH, 1024, number of words; need not be a power of 2.
ADDR_W, clog2(DEPTH), word address width.
READ_LATENCY, 2, accepted-read to readdatavalid delay in enabled cycles; legal values 1 or 2 (2 adds an output register).
CLEAR_ON_RESET, 1, 1 = scrub whole array after reset; 0 = no scrub.
INIT_VALUE, 0, DATA_W-bit word written by the scrub.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  write byte lanes
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
clken  in  1  global clock enable
reset_req  in  1  freeze request from the reset controller
waitrequest  out  1  stall; the request is not accepted while high
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata is valid this cycle
init_done  out  1  scrub complete; the slave is live

Behaviour:
- en = clken & ~reset_req. All state, RAM ports and pipeline registers advance only when en=1.
- Reset (reset_n=0, async): waitrequest=1, readdatavalid=0, readdata=0, init_done=0, scrub counter=0. In-flight reads are dropped. RAM contents are not cleared by reset itself.
- FSM states: SCRUB, RUN.
  - Leaving reset: go to SCRUB if CLEAR_ON_RESET=1, else RUN on the first enabled cycle.
  - SCRUB: while en, write INIT_VALUE with all lanes enabled to address cnt, then cnt++. On cnt=DEPTH-1 the transition goes to RUN and init_done=1 on the next edge. Scrub takes exactly DEPTH enabled cycles.
  - RUN: terminal until reset.
- waitrequest = ~(state==RUN) | ~en. This is combinational from registered state and the inputs.
- Accepted write = chipselect & write & ~waitrequest. Lane i of the word is updated iff byteenable[i]; other lanes are unchanged.
- Accepted read = chipselect & read & ~write & ~waitrequest.
- read and write both asserted: the write is performed, the read is ignored and produces no readdatavalid.
- Read latency:
  - READ_LATENCY=1: readdatavalid is registered and asserted 1 enabled cycle after acceptance.
  - READ_LATENCY=2: asserted 2 enabled cycles after acceptance.
  - Back-to-back reads sustain 1 per cycle. Responses are in order, with no gaps inserted.
- Stall: when en=0 the valid and data pipeline holds. readdatavalid output = v_last & en, so a pending response is presented in the first cycle en returns high. readdata holds its last value.
- Write then read of the same address in the next cycle returns the new data. There is no same-cycle hazard because a single command is accepted per cycle.
- Address >= DEPTH (non-power-of-2 DEPTH only): a write is dropped. A read is accepted and returns 0 with normal latency.
- readdata is undefined-free: it is 0 until the first response, then holds the last response value.
- reset_req mid-scrub: the scrub pauses and resumes at the same cnt.
- reset_n asserted mid-scrub: the scrub restarts from 0.

Decomposition:
- Package nios_ii_ocm_pkg: state enum {SCRUB, RUN}, MAX_READ_LATENCY=2, and a clog2 helper function.
- Sub-module nios_ii_ocm_bytemem: inferred single-port, byte-enabled, synchronous-read RAM with a clock enable. Parameters DATA_W and DEPTH. The top level owns the scrub mux, the FSM, the latency pipeline and the range check.

Test Plan:
- Reset release, defaults, clken=1 -> waitrequest=1 for exactly 1024 cycles, init_done rises on cycle 1024, then reading addresses 0, 511 and 1023 returns 0x00000000.
- Write 0xDEADBEEF to address 5 with byteenable=4'b1111, then write 0x11223344 to address 5 with byteenable=4'b0101, then read address 5 -> readdata=0xDE22BE44 exactly 2 cycles after acceptance.
- Read bursts of 8 consecutive addresses on back-to-back cycles -> 8 consecutive readdatavalid pulses carrying the correct data in order; repeat with READ_LATENCY=1 and check the latency is 1.
- Issue a read, then hold clken=0 for 3 cycles at the point the response is due -> readdatavalid stays 0 with data held, then asserts on the first cycle clken=1 with the correct word.
- Pulse reset_req for 10 cycles at cnt=100 during the scrub -> scrub completes after 1034 total cycles. Assert reset_n mid-scrub -> init_done=0 and the 1024-cycle count restarts.
- DEPTH=1000: write 0xA5A5A5A5 to address 1010, then read address 1010 -> readdata=0 with readdatavalid asserted. Read address 999 after scrub -> INIT_VALUE. Assert read and write together -> write applied, no readdatavalid.
